// File: rtl/uart_tx_gen2_if.sv
// Host-side bundle of the UART transmitter: write handshake, frame configuration,
// and the serial line / status outputs.
interface uart_tx_gen2_if #(
   parameter int DATA_SIZE  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_WIDTH  = 16
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic                 tx_valid;
   logic [DATA_SIZE-1:0] tx_data;
   logic                 tx_ready;
   logic                 parity_en;
   logic                 parity_odd;
   logic                 two_stop;
   logic [DIV_WIDTH-1:0] baud_div;
   logic                 tx_s;
   logic                 busy;
   logic [CW-1:0]        fifo_count;

   modport master (output tx_valid, tx_data, parity_en, parity_odd, two_stop, baud_div,
                   input  tx_ready, tx_s, busy, fifo_count);
   modport slave  (input  tx_valid, tx_data, parity_en, parity_odd, two_stop, baud_div,
                   output tx_ready, tx_s, busy, fifo_count);
endinterface

// File: rtl/uart_tx_gen2.sv
// FIFO-buffered UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Frame configuration and divisor are captured when a word is popped, so mid-frame changes wait.
module uart_tx_gen2 #(
   parameter int DATA_SIZE  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_WIDTH  = 16
) (
   input  logic          clk,
   input  logic          rst,
   uart_tx_gen2_if.slave bus
);
   localparam int         PW        = $clog2(FIFO_DEPTH);
   localparam int         CW        = PW + 1;
   localparam logic [3:0] LAST_DATA = 4'(DATA_SIZE - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t               r_state, w_next;
   logic [DATA_SIZE-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0]        r_wptr, r_rptr;
   logic [CW-1:0]        r_count;
   logic [DATA_SIZE-1:0] r_shift, w_shift_nxt;
   logic [DIV_WIDTH-1:0] r_div, r_baud, w_div_eff;
   logic [3:0]           r_bitn;
   logic                 r_par, r_pen, r_two, r_tx;
   logic                 w_tx_nxt, w_push, w_pop, w_have, w_bit_end, w_last_stop;

   assign w_have      = (r_count != '0);
   assign w_push      = bus.tx_valid && bus.tx_ready;
   assign w_bit_end   = (r_baud == '0);
   assign w_last_stop = w_bit_end && (r_bitn == {3'b000, r_two});
   assign w_pop       = w_have && ((r_state == S_IDLE) || (r_state == S_STOP && w_last_stop));
   assign w_div_eff   = (bus.baud_div == '0) ? DIV_WIDTH'(1) : bus.baud_div;

   assign bus.tx_ready   = (r_count != CW'(FIFO_DEPTH));
   assign bus.tx_s       = r_tx;
   assign bus.busy       = (r_state != S_IDLE);
   assign bus.fifo_count = r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_have) w_next = S_START;
         S_START:  if (w_bit_end) w_next = S_DATA;
         S_DATA:   if (w_bit_end && r_bitn == LAST_DATA) w_next = r_pen ? S_PARITY : S_STOP;
         S_PARITY: if (w_bit_end) w_next = S_STOP;
         S_STOP:   if (w_last_stop) w_next = w_have ? S_START : S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Line level is computed for the state being entered so tx_s comes straight off a flop.
   always_comb begin
      w_shift_nxt = r_shift;
      if (w_pop)                               w_shift_nxt = r_mem[r_rptr];
      else if (r_state == S_DATA && w_bit_end) w_shift_nxt = r_shift >> 1;
      case (w_next)
         S_START:  w_tx_nxt = 1'b0;
         S_DATA:   w_tx_nxt = w_shift_nxt[0];
         S_PARITY: w_tx_nxt = r_par;
         default:  w_tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst && w_push) r_mem[r_wptr] <= bus.tx_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         if (w_push != w_pop) r_count <= w_push ? r_count + CW'(1) : r_count - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shift <= '0;
         r_div   <= '0;
         r_baud  <= '0;
         r_bitn  <= '0;
         r_par   <= 1'b0;
         r_pen   <= 1'b0;
         r_two   <= 1'b0;
         r_tx    <= 1'b1;
      end else begin
         r_shift <= w_shift_nxt;
         r_tx    <= w_tx_nxt;
         if (w_pop) begin
            r_div  <= w_div_eff;
            r_baud <= w_div_eff - DIV_WIDTH'(1);
            r_bitn <= '0;
            r_pen  <= bus.parity_en;
            r_two  <= bus.two_stop;
            r_par  <= (^w_shift_nxt) ^ bus.parity_odd;
         end else if (r_state != S_IDLE) begin
            if (w_bit_end) begin
               r_baud <= r_div - DIV_WIDTH'(1);
               r_bitn <= (w_next != r_state) ? 4'd0 : r_bitn + 4'd1;
            end else begin
               r_baud <= r_baud - DIV_WIDTH'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_gen2.sv
// Randomised bench for uart_tx_gen2: a queue-of-words plus per-clock line-level model
// predicts tx_s/busy/fifo_count/tx_ready every cycle; scenario tasks add targeted checks.
module tb_uart_tx_gen2;
   localparam int DS   = 8;
   localparam int FD   = 4;
   localparam int DW   = 16;
   localparam int CW   = $clog2(FD) + 1;
   localparam int OW   = CW + 3;
   localparam int MAXC = 400;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   uart_tx_gen2_if #(.DATA_SIZE(DS), .FIFO_DEPTH(FD), .DIV_WIDTH(DW)) bus ();

   uart_tx_gen2 #(.DATA_SIZE(DS), .FIFO_DEPTH(FD), .DIV_WIDTH(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Model state: words waiting, and the line level for every remaining clock of the current frame.
   int unsigned mq[$];
   bit          wave[$];

   function automatic void start_frame(int unsigned w);
      int unsigned d;
      bit          bits[$];
      bit          p;
      p = 1'b0;
      d = (bus.baud_div == '0) ? 1 : int'(bus.baud_div);
      bits.push_back(1'b0);
      for (int i = 0; i < DS; i++) begin
         bits.push_back(w[i]);
         p ^= w[i];
      end
      if (bus.parity_en) bits.push_back(p ^ bus.parity_odd);
      bits.push_back(1'b1);
      if (bus.two_stop) bits.push_back(1'b1);
      foreach (bits[i]) for (int k = 0; k < int'(d); k++) wave.push_back(bits[i]);
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete();
         wave.delete();
      end else begin
         bit acc;
         acc = bus.tx_valid && (mq.size() < FD);
         if (wave.size() > 0) void'(wave.pop_front());
         if (wave.size() == 0 && mq.size() > 0) start_frame(mq.pop_front());
         if (acc) mq.push_back(int'(bus.tx_data));
      end
   end

   function automatic logic [OW-1:0] model_out();
      logic          e_tx, e_busy, e_rdy;
      logic [CW-1:0] e_cnt;
      e_busy = (wave.size() > 0);
      e_tx   = e_busy ? wave[0] : 1'b1;
      e_cnt  = CW'(mq.size());
      e_rdy  = (mq.size() < FD);
      return {e_tx, e_busy, e_cnt, e_rdy};
   endfunction

   // Stimulus plan: one entry per cycle, a word to write or -1 for no write.
   int            wrq[$];
   int            chg_at = -1;
   logic [DW-1:0] chg_div = '0;
   logic [OW-1:0] obs [MAXC];
   logic [OW-1:0] exq [MAXC];

   task automatic run(input int n);
      for (int c = 0; c < n; c++) begin
         if (wrq.size() > 0) begin
            int w;
            w = wrq.pop_front();
            bus.tx_valid = (w >= 0);
            bus.tx_data  = DS'(w);
         end else begin
            bus.tx_valid = 1'b0;
         end
         if (c == chg_at) bus.baud_div = chg_div;
         @(negedge clk);
         obs[c] = {bus.tx_s, bus.busy, bus.fifo_count, bus.tx_ready};
         exq[c] = model_out();
      end
      bus.tx_valid = 1'b0;
      chg_at = -1;
   endtask

   function automatic int first_busy(int n);
      for (int c = 0; c < n; c++) if (obs[c][OW-2]) return c;
      return -1;
   endfunction

   function automatic int busy_len(int from, int n);
      int l = 0;
      for (int c = from; c < n && obs[c][OW-2]; c++) l++;
      return l;
   endfunction

   task automatic set_cfg(input bit pe, input bit po, input bit ts, input int div);
      bus.parity_en  = pe;
      bus.parity_odd = po;
      bus.two_stop   = ts;
      bus.baud_div   = DW'(div);
   endtask

   task automatic test_reset();
      set_cfg(0, 0, 0, 4);
      bus.tx_valid = 1'b1;
      bus.tx_data  = DS'('h3C);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({bus.tx_s, bus.busy, bus.fifo_count, bus.tx_ready} !== {1'b1, 1'b0, CW'(0), 1'b1}) begin
         miscompares++;
         $display("FAIL reset_state: got tx/busy/cnt/rdy=%b want %b",
                  {bus.tx_s, bus.busy, bus.fifo_count, bus.tx_ready}, {1'b1, 1'b0, CW'(0), 1'b1});
      end
      bus.tx_valid = 1'b0;
      rst = 1'b1;
      run(8);
      for (int c = 0; c < 8; c++) begin
         vectors++;
         if (obs[c] !== exq[c]) begin
            miscompares++;
            $display("FAIL reset_idle cycle %0d: got %b want %b", c, obs[c], exq[c]);
         end
      end
   endtask

   task automatic test_a5();
      logic [9:0] seq;
      int         s, len;
      seq = {1'b1, 8'hA5, 1'b0};
      set_cfg(0, 0, 0, 4);
      wrq.push_back('hA5);
      run(50);
      for (int c = 0; c < 50; c++) begin
         vectors++;
         if (obs[c] !== exq[c]) begin
            miscompares++;
            $display("FAIL a5_wave cycle %0d: got %b want %b", c, obs[c], exq[c]);
         end
      end
      s = first_busy(50);
      if (s < 0) s = 0;
      for (int i = 0; i < 40; i++) begin
         vectors++;
         if (obs[s+i][OW-1] !== seq[i/4]) begin
            miscompares++;
            $display("FAIL a5_bit clk %0d: got %b want %b", i, obs[s+i][OW-1], seq[i/4]);
         end
      end
      len = busy_len(s, 50);
      vectors++;
      if (len !== 40) begin
         miscompares++;
         $display("FAIL a5_length: got %0d clks want 40", len);
      end
   endtask

   task automatic test_parity();
      bit pe_t[3] = '{1'b1, 1'b1, 1'b0};
      bit po_t[3] = '{1'b0, 1'b1, 1'b0};
      bit ts_t[3] = '{1'b0, 1'b0, 1'b1};
      bit pb_t[3] = '{1'b1, 1'b0, 1'b1};
      for (int k = 0; k < 3; k++) begin
         int s, len, hi;
         set_cfg(pe_t[k], po_t[k], ts_t[k], 4);
         wrq.push_back('h07);
         run(50);
         for (int c = 0; c < 50; c++) begin
            vectors++;
            if (obs[c] !== exq[c]) begin
               miscompares++;
               $display("FAIL parity_wave cfg %0d cycle %0d: got %b want %b", k, c, obs[c], exq[c]);
            end
         end
         s = first_busy(50);
         if (s < 0) s = 0;
         len = busy_len(s, 50);
         vectors++;
         if (len !== 44) begin
            miscompares++;
            $display("FAIL parity_length cfg %0d: got %0d want 44", k, len);
         end
         hi = 0;
         for (int i = 36; i < 44; i++) hi += int'(obs[s+i][OW-1]);
         vectors++;
         if (k < 2) begin
            if (obs[s+37][OW-1] !== pb_t[k]) begin
               miscompares++;
               $display("FAIL parity_bit cfg %0d: got %b want %b", k, obs[s+37][OW-1], pb_t[k]);
            end
         end else if (hi !== 8) begin
            miscompares++;
            $display("FAIL two_stop_high: got %0d clks want 8", hi);
         end
      end
   endtask

   task automatic test_back_to_back();
      int s, len;
      set_cfg(0, 0, 0, 4);
      wrq.push_back(int'($urandom_range(0, 255)));
      wrq.push_back(-1);
      wrq.push_back(-1);
      for (int i = 0; i < 5; i++) wrq.push_back(int'($urandom_range(0, 255)));
      run(210);
      for (int c = 0; c < 210; c++) begin
         vectors++;
         if (obs[c] !== exq[c]) begin
            miscompares++;
            $display("FAIL b2b_wave cycle %0d: got %b want %b", c, obs[c], exq[c]);
         end
      end
      vectors++;
      if ({obs[5][CW:1], obs[5][0]} !== {CW'(3), 1'b1}) begin
         miscompares++;
         $display("FAIL b2b_count3: got cnt=%0d rdy=%b want 3/1", obs[5][CW:1], obs[5][0]);
      end
      vectors++;
      if ({obs[6][CW:1], obs[6][0]} !== {CW'(4), 1'b0}) begin
         miscompares++;
         $display("FAIL b2b_full: got cnt=%0d rdy=%b want 4/0", obs[6][CW:1], obs[6][0]);
      end
      vectors++;
      if (obs[7][CW:1] !== CW'(4)) begin
         miscompares++;
         $display("FAIL b2b_overflow_ignored: got cnt=%0d want 4", obs[7][CW:1]);
      end
      s = first_busy(210);
      if (s < 0) s = 0;
      len = busy_len(s, 210);
      vectors++;
      if (len !== 200) begin
         miscompares++;
         $display("FAIL b2b_no_gap: got %0d busy clks want 200", len);
      end
   endtask

   task automatic test_baud_change();
      int unsigned w0, w1;
      int          s, len;
      w0 = $urandom_range(0, 255) | 1;
      w1 = $urandom_range(0, 255) | 1;
      set_cfg(0, 0, 0, 4);
      wrq.push_back(int'(w0));
      wrq.push_back(int'(w1));
      chg_at  = 3;
      chg_div = DW'(8);
      run(130);
      for (int c = 0; c < 130; c++) begin
         vectors++;
         if (obs[c] !== exq[c]) begin
            miscompares++;
            $display("FAIL baud_wave cycle %0d: got %b want %b", c, obs[c], exq[c]);
         end
      end
      s = first_busy(130);
      if (s < 0) s = 0;
      len = busy_len(s, 130);
      vectors++;
      if (len !== 120) begin
         miscompares++;
         $display("FAIL baud_total: got %0d clks want 120", len);
      end
      vectors++;
      if (obs[s+4][OW-1] !== 1'b1) begin
         miscompares++;
         $display("FAIL baud_old_frame: got tx=%b want 1", obs[s+4][OW-1]);
      end
      vectors++;
      if (obs[s+44][OW-1] !== 1'b0) begin
         miscompares++;
         $display("FAIL baud_new_frame: got tx=%b want 0", obs[s+44][OW-1]);
      end
      bus.baud_div = '0;
      wrq.push_back(int'($urandom_range(0, 255)));
      run(20);
      for (int c = 0; c < 20; c++) begin
         vectors++;
         if (obs[c] !== exq[c]) begin
            miscompares++;
            $display("FAIL div0_wave cycle %0d: got %b want %b", c, obs[c], exq[c]);
         end
      end
      s = first_busy(20);
      if (s < 0) s = 0;
      len = busy_len(s, 20);
      vectors++;
      if (len !== 10) begin
         miscompares++;
         $display("FAIL div0_length: got %0d clks want 10", len);
      end
   endtask

   task automatic test_full_minus_one();
      int s, len;
      set_cfg(0, 0, 0, 4);
      for (int i = 0; i < 4; i++) wrq.push_back(int'($urandom_range(0, 255)));
      repeat (37) wrq.push_back(-1);
      wrq.push_back(int'($urandom_range(0, 255)));
      run(215);
      for (int c = 0; c < 215; c++) begin
         vectors++;
         if (obs[c] !== exq[c]) begin
            miscompares++;
            $display("FAIL fm1_wave cycle %0d: got %b want %b", c, obs[c], exq[c]);
         end
      end
      vectors++;
      if ({obs[40][CW:1], obs[41][CW:1]} !== {CW'(3), CW'(3)}) begin
         miscompares++;
         $display("FAIL fm1_count: got %0d,%0d want 3,3", obs[40][CW:1], obs[41][CW:1]);
      end
      s = first_busy(215);
      if (s < 0) s = 0;
      len = busy_len(s, 215);
      vectors++;
      if (len !== 200) begin
         miscompares++;
         $display("FAIL fm1_length: got %0d clks want 200", len);
      end
   endtask

   task automatic test_reset_mid();
      int s, len;
      set_cfg(0, 0, 0, 4);
      for (int i = 0; i < 3; i++) wrq.push_back(int'($urandom_range(0, 255)));
      run(18);
      vectors++;
      if (obs[17][CW:1] !== CW'(2)) begin
         miscompares++;
         $display("FAIL rmid_queued: got %0d want 2", obs[17][CW:1]);
      end
      #2 rst = 1'b0;
      #1;
      vectors++;
      if ({bus.tx_s, bus.busy, bus.fifo_count, bus.tx_ready} !== {1'b1, 1'b0, CW'(0), 1'b1}) begin
         miscompares++;
         $display("FAIL rmid_immediate: got %b want %b",
                  {bus.tx_s, bus.busy, bus.fifo_count, bus.tx_ready}, {1'b1, 1'b0, CW'(0), 1'b1});
      end
      repeat (3) @(negedge clk);
      vectors++;
      if ({bus.tx_s, bus.busy, bus.fifo_count, bus.tx_ready} !== {1'b1, 1'b0, CW'(0), 1'b1}) begin
         miscompares++;
         $display("FAIL rmid_held: got %b want %b",
                  {bus.tx_s, bus.busy, bus.fifo_count, bus.tx_ready}, {1'b1, 1'b0, CW'(0), 1'b1});
      end
      rst = 1'b1;
      run(60);
      for (int c = 0; c < 60; c++) begin
         vectors++;
         if (obs[c] !== exq[c]) begin
            miscompares++;
            $display("FAIL rmid_idle cycle %0d: got %b want %b", c, obs[c], exq[c]);
         end
      end
      vectors++;
      if (first_busy(60) !== -1) begin
         miscompares++;
         $display("FAIL rmid_no_frame: got busy at cycle %0d want none", first_busy(60));
      end
      wrq.push_back(int'($urandom_range(0, 255)));
      run(50);
      for (int c = 0; c < 50; c++) begin
         vectors++;
         if (obs[c] !== exq[c]) begin
            miscompares++;
            $display("FAIL rmid_after cycle %0d: got %b want %b", c, obs[c], exq[c]);
         end
      end
      s = first_busy(50);
      if (s < 0) s = 0;
      len = busy_len(s, 50);
      vectors++;
      if (len !== 40) begin
         miscompares++;
         $display("FAIL rmid_new_frame: got %0d clks want 40", len);
      end
   endtask

   task automatic test_random();
      for (int b = 0; b < 6; b++) begin
         set_cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)));
         for (int i = 0; i < 8; i++) begin
            wrq.push_back(int'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 3)) wrq.push_back(-1);
         end
         chg_at  = int'($urandom_range(5, 60));
         chg_div = DW'($urandom_range(0, 3));
         run(360);
         for (int c = 0; c < 360; c++) begin
            vectors++;
            if (obs[c] !== exq[c]) begin
               miscompares++;
               $display("FAIL random burst %0d cycle %0d: got %b want %b", b, c, obs[c], exq[c]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_a5();
      test_parity();
      test_back_to_back();
      test_baud_change();
      test_full_minus_one();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
